// File: rtl/bnn_pkg.sv
// Constants and state type shared by the BNN inference chain (fc, fc_argmax, top).
package bnn_pkg;

  localparam int NUM_CLASS   = 10;
  localparam int FC_DATA_W   = 32;
  localparam int CLASS_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } argmax_state_e;

endpackage

// File: rtl/fc_argmax.sv
// Running argmax over one frame of NUM_CLASS signed fc scores; one-cycle result pulse.
// Optional score buffer readback enabled with `define FC_ARGMAX_SCORE_BUF_EN.
module fc_argmax #(
  parameter int NUM_CLASS = bnn_pkg::NUM_CLASS,
  parameter int DATA_W    = bnn_pkg::FC_DATA_W,
  parameter int IDX_W     = bnn_pkg::CLASS_IDX_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     ivalid,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     clr,
  output logic                     ovalid,
  output logic        [IDX_W-1:0]  class_idx,
  output logic signed [DATA_W-1:0] max_score,
  output logic                     busy,
  input  logic        [IDX_W-1:0]  rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);
  import bnn_pkg::*;

  // state | meaning
  // IDLE  | cnt=0, waiting for the first score of a frame
  // ACC   | cnt in 1..NUM_CLASS-1, accumulating the running max

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASS - 1);

  argmax_state_e             state_q, state_d;
  logic        [IDX_W-1:0]   cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  run_max_q, run_max_d;
  logic        [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic        [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0]  max_score_q, max_score_d;
  logic                      ovalid_q, ovalid_d;
  logic                      upd;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      class_idx_q <= '0;
      max_score_q <= '0;
      ovalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      class_idx_q <= class_idx_d;
      max_score_q <= max_score_d;
      ovalid_q    <= ovalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    class_idx_d = class_idx_q;
    max_score_d = max_score_q;
    ovalid_d    = 1'b0;
    // strict greater-than so ties keep the lower index
    upd = (state_q == IDLE) || (din > run_max_q);

    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (ivalid) begin
      if (upd) begin
        run_max_d = din;
        run_idx_d = cnt_q;
      end
      if (cnt_q == LAST) begin
        class_idx_d = upd ? cnt_q : run_idx_q;
        max_score_d = upd ? din : run_max_q;
        ovalid_d    = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ACC;
      end
    end
  end

  assign ovalid    = ovalid_q;
  assign class_idx = class_idx_q;
  assign max_score = max_score_q;
  assign busy      = (cnt_q != '0);

`ifdef FC_ARGMAX_SCORE_BUF_EN
  logic signed [DATA_W-1:0] score_buf_q [NUM_CLASS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (!rstn) begin
        score_buf_q[i] <= '0;
      end else if (ivalid && !clr && (cnt_q == IDX_W'(i))) begin
        score_buf_q[i] <= din;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CLASS; i++) begin
      if (rd_addr == IDX_W'(i)) rd_data = score_buf_q[i];
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: driver queues expected results, negedge monitor checks them.
module tb_fc_argmax;

  logic               clk = 1'b0;
  logic               rstn;
  logic               ivalid;
  logic signed [31:0] din;
  logic               clr;
  logic               ovalid;
  logic        [3:0]  class_idx;
  logic signed [31:0] max_score;
  logic               busy;
  logic        [3:0]  rd_addr;
  logic signed [31:0] rd_data;

  fc_argmax dut (
    .clk       (clk),
    .rstn      (rstn),
    .ivalid    (ivalid),
    .din       (din),
    .clr       (clr),
    .ovalid    (ovalid),
    .class_idx (class_idx),
    .max_score (max_score),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        [3:0]  idx;
    logic signed [31:0] mx;
    int                 due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ovalid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ovalid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ovalid_cycle", cyc, e.due);
        chk("class_idx", class_idx, e.idx);
        chk("max_score", $signed(max_score), $signed(e.mx));
      end
    end
  end

  typedef logic signed [31:0] frame_t [10];

  task automatic run_frame(input frame_t s, input bit gap,
                           input logic [3:0] eidx, input logic signed [31:0] emax);
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      ivalid = 1'b1;
      din    = s[i];
      if (i == 9) begin
        e.idx = eidx; e.mx = emax; e.due = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
      ivalid = 1'b0;
      if (gap) begin
        chk("busy_gapped", busy, (i < 9) ? 1 : 0);
        if (i < 9) @(negedge clk);
      end
    end
  endtask

  frame_t f;

  initial begin
    rstn = 1'b0; ivalid = 1'b0; din = '0; clr = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_max_score", max_score, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    @(negedge clk);

    // ties keep the lower index
    f = '{-5, 3, 12, 7, -100, 12, 0, 1, 2, -3};
    run_frame(f, 1'b0, 4'd2, 32'sd12);
`ifdef FC_ARGMAX_SCORE_BUF_EN
    rd_addr = 4'd5;  #1 chk("rd_addr5", $signed(rd_data), 12);
    rd_addr = 4'd4;  #1 chk("rd_addr4", $signed(rd_data), -100);
    rd_addr = 4'd12; #1 chk("rd_addr12", $signed(rd_data), 0);
    rd_addr = 4'd0;
`else
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1 chk("rd_data_tied", $signed(rd_data), 0);
    end
    rd_addr = 4'd0;
    @(negedge clk);
`endif

    // signed compare
    f = '{-50, -40, -7, -8, -9, -60, -7, -100, 32'sh8000_0000, -11};
    run_frame(f, 1'b0, 4'd2, -32'sd7);
    @(negedge clk);

    // 1-on/1-off gapped input
    f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 99};
    run_frame(f, 1'b1, 4'd9, 32'sd99);
    @(negedge clk);

    // back-to-back frames with continuous ivalid
    f = '{1, 2, 3, 4, 500, 5, 6, 7, 8, 500};
    run_frame(f, 1'b0, 4'd4, 32'sd500);
    f = '{1, 0, -1, 1, 0, 1, -5, 1, 0, 1};
    run_frame(f, 1'b0, 4'd0, 32'sd1);
    @(negedge clk);

    // abort: partial frame with 1000, clr beats a simultaneous ivalid
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; din = (i == 1) ? 32'sd1000 : 32'(i);
      @(negedge clk);
    end
    chk("busy_partial", busy, 1);
    clr = 1'b1; din = 32'sd5000;
    @(negedge clk);
    clr = 1'b0; ivalid = 1'b0;
    chk("busy_after_clr", busy, 0);
    chk("hold_idx_after_clr", class_idx, 0);
    chk("hold_max_after_clr", $signed(max_score), 1);
    f = '{0, 1, 2, 3, 4, 5, 30, 6, 7, 8};
    run_frame(f, 1'b0, 4'd6, 32'sd30);
    @(negedge clk);

    // reset mid-frame discards the frame
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1; din = 32'sd2000 + 32'(i);
      @(negedge clk);
    end
    rstn = 1'b0; ivalid = 1'b0;
    @(negedge clk);
    chk("midrst_ovalid", ovalid, 0);
    chk("midrst_class_idx", class_idx, 0);
    chk("midrst_max_score", max_score, 0);
    chk("midrst_busy", busy, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
